ro_sampler: RTL

//  Downstream consumer of one ring oscillator: gates the oscillator via its halt input,

---
 rtl/trng_pkg.sv | 21 ++
 rtl/bit_sync.sv | 33 +++
 rtl/ro_sampler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// +----------------------------------------------------------------------------+
// | trng_pkg                                                                   |
// | FSM state encoding and defaults shared by the TRNG pipeline stages.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package trng_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_WARM    = 2'd1;
  localparam state_t ST_COLLECT = 2'd2;
  localparam state_t ST_HOLD    = 2'd3;

  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
// +----------------------------------------------------------------------------+
// | bit_sync                                                                   |
// | Multi-flop synchroniser for a single asynchronous bit.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bit_sync
  import trng_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/ro_sampler.sv
// +----------------------------------------------------------------------------+
// | ro_sampler                                                                 |
// | Gates a ring oscillator, samples its synchronised output on a divider and  |
// | packs bits into words offered on valid/ready.                              |
// | Optional debias: define RO_SAMPLER_VON_NEUMANN_EN.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ro_sampler
  import trng_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIV         = 4,
  parameter int WARMUP      = 16,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             ro_signal,
  output logic             ro_enable,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy
);

  localparam int WARM_W = $clog2(WARMUP + 1);
  localparam int DIV_W  = $clog2(DIV + 1);
  localparam int BIT_W  = $clog2(WIDTH + 1);

  localparam logic [WARM_W-1:0] C_WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(WIDTH - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [WARM_W-1:0] r_warm_cnt;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [WIDTH-1:0]  r_sh;
  logic [WIDTH-1:0]  r_data;
  logic              r_data_valid;
  logic              r_ro_enable;
  logic              w_sample;
  logic              w_collecting;
  logic              w_tick;
  logic              w_accept;
  logic              w_bit;
  logic              w_last_bit;
  logic              w_handshake;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (ro_signal),
    .q     (w_sample)
  );

  assign w_collecting = (r_state == ST_COLLECT) && run;
  assign w_tick       = w_collecting && (r_div_cnt == C_DIV_LAST);
  assign w_handshake  = r_data_valid && data_ready;

`ifdef RO_SAMPLER_VON_NEUMANN_EN
  // First sample of a pair is parked; only unequal pairs yield a bit.
  logic r_pair_have;
  logic r_pair_a;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pair_have <= 1'b0;
      r_pair_a    <= 1'b0;
    end else if (w_tick) begin
      r_pair_have <= ~r_pair_have;
      if (!r_pair_have) begin
        r_pair_a <= w_sample;
      end
    end else if (!w_collecting) begin
      r_pair_have <= 1'b0;
    end
  end

  assign w_accept = w_tick && r_pair_have && (r_pair_a != w_sample);
  assign w_bit    = r_pair_a;
`else
  assign w_accept = w_tick;
  assign w_bit    = w_sample;
`endif

  assign w_last_bit = w_accept && (r_bit_cnt == C_BIT_LAST);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (run) w_next_state = ST_WARM;
      end
      ST_WARM: begin
        if (!run)                           w_next_state = ST_IDLE;
        else if (r_warm_cnt == C_WARM_LAST) w_next_state = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!run)            w_next_state = ST_IDLE;
        else if (w_last_bit) w_next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_handshake) w_next_state = run ? ST_COLLECT : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ro_enable  <= 1'b1;
      r_warm_cnt   <= '0;
      r_div_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_sh         <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_ro_enable <= (w_next_state == ST_IDLE);

      if (r_state == ST_WARM && run) begin
        r_warm_cnt <= (r_warm_cnt == C_WARM_LAST) ? '0 : r_warm_cnt + 1'b1;
      end else begin
        r_warm_cnt <= '0;
      end

      // HOLD freezes the divider; any exit other than COLLECT/HOLD drops the partial word.
      if (w_collecting) begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
        if (w_accept) begin
          r_sh      <= {r_sh[WIDTH-2:0], w_bit};
          r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
        end
      end else if (r_state != ST_HOLD) begin
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
        r_sh      <= '0;
      end

      if (w_last_bit) begin
        r_data       <= {r_sh[WIDTH-2:0], w_bit};
        r_data_valid <= 1'b1;
      end else if (w_handshake) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign ro_enable  = r_ro_enable;
  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire
